osc_control_regs: RTL and testbench

Downstream consumer of the 16-bit SPI receiver. Decodes each received word into oscillator control registers: a 32-bit phase increment assembled from three ordered words, plus a waveform select and an output level. Outputs are held stable between updates. They feed the phase accumulator and wave-shaping stages, all in the same clock domain.

---
 rtl/osc_pkg.sv | 38 +++
 rtl/edge_detect_rise.sv | 35 +++
 rtl/osc_control_regs.sv | 130 +++++++++++++
 tb/tb_osc_control_regs.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscillator control register block:
//   - opcode constants carried in word bits [15:12]
//   - frequency-sequence state encoding
//   - field widths for phase increment, level and payload
//   - saturating counter helper
// -----------------------------------------------------------------------------
package osc_pkg;

    localparam int PHASE_W   = 32;
    localparam int LEVEL_W   = 12;
    localparam int PAYLOAD_W = 12;
    localparam int OPCODE_W  = 4;
    localparam int ERR_W     = 8;

    localparam logic [OPCODE_W-1:0] OP_FREQ_LO  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_FREQ_MID = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_FREQ_HI  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_WAVE     = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LEVEL    = 4'h5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_LO  = 2'd1,
        GOT_MID = 2'd2
    } osc_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc8(input logic [ERR_W-1:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// -----------------------------------------------------------------------------
// edge_detect_rise
// Turns a level-style strobe into a single-cycle rise indication.
// The previous sample resets to RESET_LEVEL; with the default of 1 a level
// that is already high when reset releases does not count as a rise.
// Ports:
//   clock     in  1  system clock, posedge
//   reset     in  1  asynchronous, active-high
//   level_in  in  1  level-style strobe
//   rise      out 1  high while level_in is high and the registered sample is low
// -----------------------------------------------------------------------------
module edge_detect_rise #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level_in,
    output logic rise
);

    logic level_q_r;

    // Register the previous sample of the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q_r <= RESET_LEVEL;
        end else begin
            level_q_r <= level_in;
        end
    end

    // Rise is combinational so the word is decoded on the same edge it is seen.
    assign rise = level_in & ~level_q_r;

endmodule

// File: rtl/osc_control_regs.sv
// -----------------------------------------------------------------------------
// osc_control_regs
// Decodes 16-bit words from the SPI receiver into oscillator controls.
// A phase increment is assembled from three ordered words (LO, MID, HI) and
// committed on HI; waveform and level are written directly by single words.
// An abandoned frequency sequence times out back to IDLE.
// Ports:
//   clock        in  1   system clock, posedge
//   reset        in  1   asynchronous, active-high
//   data_in      in  16  received word, [15:12] opcode, [11:0] payload
//   data_valid   in  1   level strobe from the receiver, one word per rise
//   phase_inc    out 32  committed phase increment
//   waveform     out 2   waveform select
//   level        out 12  output amplitude
//   freq_update  out 1   one-cycle pulse when phase_inc is committed
//   error_count  out 8   saturating protocol error count
// -----------------------------------------------------------------------------
module osc_control_regs
    import osc_pkg::*;
#(
    parameter logic [15:0]        TIMEOUT     = 16'h0FFF,
    parameter logic [PHASE_W-1:0] DEFAULT_INC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        data_in,
    input  logic               data_valid,
    output logic [PHASE_W-1:0] phase_inc,
    output logic [1:0]         waveform,
    output logic [LEVEL_W-1:0] level,
    output logic               freq_update,
    output logic [ERR_W-1:0]   error_count
);

    logic                  accept_s;
    logic [OPCODE_W-1:0]   opcode_s;
    logic [PAYLOAD_W-1:0]  payload_s;

    osc_state_e            state_r;
    logic [PAYLOAD_W-1:0]  stage_lo_r;
    logic [PAYLOAD_W-1:0]  stage_mid_r;
    // One bit wider than TIMEOUT so the "greater than" test cannot wrap.
    logic [16:0]           idle_cnt_r;

    assign opcode_s  = data_in[15:12];
    assign payload_s = data_in[11:0];

    edge_detect_rise #(
        .RESET_LEVEL (1'b1)
    ) u_dv_rise (
        .clock    (clock),
        .reset    (reset),
        .level_in (data_valid),
        .rise     (accept_s)
    );

    // Word decode, frequency sequence FSM, timeout counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            stage_lo_r  <= 12'h000;
            stage_mid_r <= 12'h000;
            idle_cnt_r  <= 17'd0;
            phase_inc   <= DEFAULT_INC;
            waveform    <= 2'd0;
            level       <= 12'h000;
            freq_update <= 1'b0;
            error_count <= 8'h00;
        end else begin
            freq_update <= 1'b0;
            if (accept_s) begin
                // An accepted word always restarts the idle count, so it wins
                // over a timeout that would otherwise fire this cycle.
                idle_cnt_r <= 17'd0;
                case (opcode_s)
                    OP_FREQ_LO: begin
                        // LO is always taken; mid-sequence it restarts and counts an error.
                        stage_lo_r <= payload_s;
                        state_r    <= GOT_LO;
                        if (state_r != IDLE) begin
                            error_count <= sat_inc8(error_count);
                        end else begin
                            error_count <= error_count;
                        end
                    end
                    OP_FREQ_MID: begin
                        if (state_r == GOT_LO) begin
                            stage_mid_r <= payload_s;
                            state_r     <= GOT_MID;
                        end else begin
                            state_r     <= IDLE;
                            error_count <= sat_inc8(error_count);
                        end
                    end
                    OP_FREQ_HI: begin
                        // payload[11:8] carries no phase bits and is dropped.
                        if (state_r == GOT_MID) begin
                            phase_inc   <= {payload_s[7:0], stage_mid_r, stage_lo_r};
                            freq_update <= 1'b1;
                            state_r     <= IDLE;
                        end else begin
                            state_r     <= IDLE;
                            error_count <= sat_inc8(error_count);
                        end
                    end
                    OP_WAVE: begin
                        waveform <= payload_s[1:0];
                    end
                    OP_LEVEL: begin
                        level <= payload_s;
                    end
                    default: begin
                        error_count <= sat_inc8(error_count);
                    end
                endcase
            end else if (state_r != IDLE) begin
                if (idle_cnt_r > {1'b0, TIMEOUT}) begin
                    state_r     <= IDLE;
                    idle_cnt_r  <= 17'd0;
                    error_count <= sat_inc8(error_count);
                end else begin
                    idle_cnt_r <= idle_cnt_r + 17'd1;
                end
            end else begin
                idle_cnt_r <= 17'd0;
            end
        end
    end

endmodule

// File: tb/tb_osc_control_regs.sv
// -----------------------------------------------------------------------------
// tb_osc_control_regs
// Directed, table-driven bench for osc_control_regs plus hand-written
// sequences for timeout, accept-versus-timeout, saturation and reset.
// -----------------------------------------------------------------------------
module tb_osc_control_regs;

    localparam int TO = 4095;   // TIMEOUT value of the design (16'h0FFF)

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic [31:0] phase_inc;
    logic [1:0]  waveform;
    logic [11:0] level;
    logic        freq_update;
    logic [7:0]  error_count;

    osc_control_regs dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .phase_inc   (phase_inc),
        .waveform    (waveform),
        .level       (level),
        .freq_update (freq_update),
        .error_count (error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    // Count freq_update cycles, sampled mid-cycle.
    always @(negedge clock) begin
        if (freq_update === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    typedef struct {
        logic [15:0] word;
        int          hold;
        logic [31:0] exp_pi;
        logic [1:0]  exp_wave;
        logic [11:0] exp_level;
        logic [7:0]  exp_err;
        int          exp_pulses;
    } vec_t;

    localparam int NV = 29;
    vec_t tv [NV];

    function automatic vec_t mk(input logic [15:0] w, input int h, input logic [31:0] pi,
                                input logic [1:0] wv, input logic [11:0] lv,
                                input logic [7:0] e, input int p);
        vec_t v;
        v.word = w; v.hold = h; v.exp_pi = pi; v.exp_wave = wv;
        v.exp_level = lv; v.exp_err = e; v.exp_pulses = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a word (caller guarantees data_valid was low at the previous
    // edge), hold it for extra cycles, then drop data_valid for one edge.
    task automatic send_word(input logic [15:0] w, input int hold, output logic fu);
        data_in    = w;
        data_valid = 1'b1;
        @(posedge clock); #1;
        fu = freq_update;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pi, input logic [1:0] wv,
                           input logic [11:0] lv, input logic [7:0] e);
        chk({tag, ".phase_inc"},   phase_inc,            pi);
        chk({tag, ".waveform"},    {30'd0, waveform},    {30'd0, wv});
        chk({tag, ".level"},       {20'd0, level},       {20'd0, lv});
        chk({tag, ".error_count"}, {24'd0, error_count}, {24'd0, e});
    endtask

    initial begin
        logic fu;
        int   p0;

        tv[0]  = mk(16'h1ABC, 0,  32'h0000_0000, 2'd0, 12'h000, 8'd0, 0);
        tv[1]  = mk(16'h2DEF, 1,  32'h0000_0000, 2'd0, 12'h000, 8'd0, 0);
        tv[2]  = mk(16'h3012, 2,  32'h12DE_FABC, 2'd0, 12'h000, 8'd0, 1);
        tv[3]  = mk(16'h4003, 50, 32'h12DE_FABC, 2'd3, 12'h000, 8'd0, 0);
        tv[4]  = mk(16'h1001, 0,  32'h12DE_FABC, 2'd3, 12'h000, 8'd0, 0);
        tv[5]  = mk(16'h5123, 0,  32'h12DE_FABC, 2'd3, 12'h123, 8'd0, 0);
        tv[6]  = mk(16'h2002, 0,  32'h12DE_FABC, 2'd3, 12'h123, 8'd0, 0);
        tv[7]  = mk(16'h3003, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd0, 1);
        tv[8]  = mk(16'h3777, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd1, 0);
        tv[9]  = mk(16'h2777, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd2, 0);
        tv[10] = mk(16'h1010, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd2, 0);
        tv[11] = mk(16'h3444, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd3, 0);
        tv[12] = mk(16'h2555, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd4, 0);
        tv[13] = mk(16'h1020, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd4, 0);
        tv[14] = mk(16'h1030, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd5, 0);
        tv[15] = mk(16'h2040, 0,  32'h0300_2001, 2'd3, 12'h123, 8'd5, 0);
        tv[16] = mk(16'h3F50, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd5, 1);
        tv[17] = mk(16'h0123, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd6, 0);
        tv[18] = mk(16'h6000, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd7, 0);
        tv[19] = mk(16'h1AAA, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd7, 0);
        tv[20] = mk(16'h7FFF, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd8, 0);
        tv[21] = mk(16'h2BBB, 0,  32'h5004_0030, 2'd3, 12'h123, 8'd8, 0);
        tv[22] = mk(16'h3CCC, 0,  32'hCCBB_BAAA, 2'd3, 12'h123, 8'd8, 1);
        tv[23] = mk(16'h1111, 0,  32'hCCBB_BAAA, 2'd3, 12'h123, 8'd8, 0);
        tv[24] = mk(16'h2222, 0,  32'hCCBB_BAAA, 2'd3, 12'h123, 8'd8, 0);
        tv[25] = mk(16'h4001, 0,  32'hCCBB_BAAA, 2'd1, 12'h123, 8'd8, 0);
        tv[26] = mk(16'h3033, 0,  32'h3322_2111, 2'd1, 12'h123, 8'd8, 1);
        tv[27] = mk(16'h4FFE, 0,  32'h3322_2111, 2'd2, 12'h123, 8'd8, 0);
        tv[28] = mk(16'h5FFF, 0,  32'h3322_2111, 2'd2, 12'hFFF, 8'd8, 0);

        reset      = 1'b1;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_all("reset", 32'h0, 2'd0, 12'h000, 8'd0);
        chk("reset.freq_update", {31'd0, freq_update}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Table-driven words; state carries over from one vector to the next.
        for (int i = 0; i < NV; i++) begin
            p0 = pulse_cnt;
            send_word(tv[i].word, tv[i].hold, fu);
            chk_all($sformatf("vec%0d", i), tv[i].exp_pi, tv[i].exp_wave,
                    tv[i].exp_level, tv[i].exp_err);
            chk($sformatf("vec%0d.fu_at_accept", i), {31'd0, fu},
                (tv[i].exp_pulses != 0) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d.pulses", i), pulse_cnt - p0, tv[i].exp_pulses);
        end

        // Timeout: LO accepted at edge N; no timeout through N+TO+1, error at N+TO+2.
        send_word(16'h1111, 0, fu);                 // now just after edge N+1
        repeat (TO) @(posedge clock);               // edge N+4096
        #1;
        chk("timeout.before", {24'd0, error_count}, 32'd8);
        @(posedge clock); #1;                       // edge N+4097
        chk("timeout.fire", {24'd0, error_count}, 32'd9);
        send_word(16'h3022, 0, fu);
        chk("timeout.hi_err", {24'd0, error_count}, 32'd10);
        chk("timeout.pi_kept", phase_inc, 32'h3322_2111);

        // Accept on the same edge the timeout would fire: word wins.
        send_word(16'h1010, 0, fu);
        repeat (TO) @(posedge clock);
        #1;
        send_word(16'h2020, 0, fu);                 // accepted at edge N+4097
        chk("accept_wins.err", {24'd0, error_count}, 32'd10);
        send_word(16'h3030, 0, fu);
        chk("accept_wins.pi", phase_inc, 32'h3002_0010);
        chk("accept_wins.fu", {31'd0, fu}, 32'd1);

        // Saturation of the error counter.
        for (int i = 0; i < 245; i++) send_word(16'hF000, 0, fu);
        chk("sat.reach", {24'd0, error_count}, 32'hFF);
        for (int i = 0; i < 55; i++) send_word(16'hF000, 0, fu);
        chk("sat.hold", {24'd0, error_count}, 32'hFF);

        // Asynchronous reset mid-sequence, checked before any clock edge.
        send_word(16'h1ABC, 0, fu);
        send_word(16'h2DEF, 0, fu);
        #3;
        reset = 1'b1;
        #1;
        chk_all("midreset", 32'h0, 2'd0, 12'h000, 8'd0);
        chk("midreset.freq_update", {31'd0, freq_update}, 32'd0);

        // data_valid already high when reset releases must not be accepted.
        data_in    = 16'hF000;
        data_valid = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("dv_high_at_release", {24'd0, error_count}, 32'd0);
        data_valid = 1'b0;
        @(posedge clock); #1;

        // Staged words were discarded: HI is now illegal.
        send_word(16'h3012, 0, fu);
        chk("post_reset.hi_err", {24'd0, error_count}, 32'd1);
        chk("post_reset.pi", phase_inc, 32'h0);
        send_word(16'h1ABC, 0, fu);
        send_word(16'h2DEF, 0, fu);
        p0 = pulse_cnt;
        send_word(16'h3012, 0, fu);
        chk("post_reset.commit", phase_inc, 32'h12DE_FABC);
        chk("post_reset.pulses", pulse_cnt - p0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
